// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error injector.
// The LFSR polynomial is fixed here so that the design and any reference model agree on one value.
package chan_err_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_WINDOW   = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_RANDOM   = 2'd3
    } chan_mode_e;

    localparam logic [15:0] LFSR_POLY      = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DFLT = 16'hACE1;

    // Number of set bits in a mask of up to 32 bits.
    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] cnt;
        cnt = 32'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/chan_lfsr.sv
// 16-bit right-shifting Galois LFSR with advance enable and synchronous reseed.
// A zero seed is replaced by the default so the lock-up state can never be loaded.
module chan_lfsr
    import chan_err_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic        reseed,
    output logic [15:0] state
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_SEED_DFLT : SEED;

    logic [15:0] lfsr_r;
    logic [15:0] lfsr_nx_s;

    // Next state: reseed wins over advance, otherwise hold.
    always_comb begin
        lfsr_nx_s = lfsr_r;
        if (reseed) begin
            lfsr_nx_s = SEED_EFF;
        end else if (adv) begin
            lfsr_nx_s = (lfsr_r >> 1) ^ (lfsr_r[0] ? LFSR_POLY : 16'h0000);
        end else begin
            lfsr_nx_s = lfsr_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= SEED_EFF;
        end else begin
            lfsr_r <= lfsr_nx_s;
        end
    end

    assign state = lfsr_r;

endmodule

// File: rtl/chan_err_inj.sv
// Channel error injector: corrupts encoder symbols by window, periodic burst or LFSR
// and forwards corrupted and clean symbols with an error flag and saturating BER counters.
module chan_err_inj
    import chan_err_pkg::*;
#(
    parameter int          W     = 2,
    parameter int          CNT_W = 32,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [W-1:0]     sym_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] cfg_start_i,
    input  logic [CNT_W-1:0] cfg_len_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [15:0]      cfg_thresh_i,
    input  logic [W-1:0]     cfg_mask_i,
    input  logic             clear_i,
    output logic             valid_o,
    output logic [W-1:0]     sym_o,
    output logic [W-1:0]     golden_o,
    output logic             err_o,
    output logic [CNT_W-1:0] sym_ct_o,
    output logic [CNT_W-1:0] bit_err_ct_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    chan_mode_e       mode_s;
    logic             hit_s;
    logic [15:0]      lfsr_s;
    logic [CNT_W-1:0] idx_r;
    logic [CNT_W-1:0] phase_r;
    logic [CNT_W-1:0] idx_nx_s;
    logic [CNT_W-1:0] phase_nx_s;
    logic [CNT_W:0]   bit_sum_s;
    logic [CNT_W-1:0] bit_nx_s;
    logic [31:0]      pop_s;

    assign mode_s = chan_mode_e'(mode_i);
    assign pop_s  = popcount(32'(cfg_mask_i));

    chan_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .adv    (valid_i),
        .reseed (clear_i),
        .state  (lfsr_s)
    );

    // Hit decision from the pre-increment index, phase and LFSR state.
    always_comb begin
        hit_s = 1'b0;
        case (mode_s)
            MODE_OFF:      hit_s = 1'b0;
            MODE_WINDOW:   hit_s = (idx_r >= cfg_start_i) && ((idx_r - cfg_start_i) < cfg_len_i);
            MODE_PERIODIC: hit_s = (cfg_period_i != '0) && (phase_r < cfg_len_i);
            MODE_RANDOM:   hit_s = (lfsr_s < cfg_thresh_i);
            default:       hit_s = 1'b0;
        endcase
    end

    // Saturating index/counter increments and phase wrap (>= also recovers from a shrunk period).
    always_comb begin
        idx_nx_s   = idx_r;
        phase_nx_s = phase_r;
        bit_sum_s  = {1'b0, bit_err_ct_o} + (CNT_W+1)'(pop_s);
        if (idx_r == '1) begin
            idx_nx_s = idx_r;
        end else begin
            idx_nx_s = idx_r + ONE;
        end
        if ((cfg_period_i == '0) || (phase_r >= cfg_period_i - ONE)) begin
            phase_nx_s = '0;
        end else begin
            phase_nx_s = phase_r + ONE;
        end
        if (bit_sum_s[CNT_W]) begin
            bit_nx_s = '1;
        end else begin
            bit_nx_s = bit_sum_s[CNT_W-1:0];
        end
    end

    // Output pipeline register and statistics state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o      <= 1'b0;
            sym_o        <= '0;
            golden_o     <= '0;
            err_o        <= 1'b0;
            idx_r        <= '0;
            phase_r      <= '0;
            bit_err_ct_o <= '0;
        end else begin
            valid_o <= valid_i;
            if (clear_i) begin
                idx_r        <= '0;
                phase_r      <= '0;
                bit_err_ct_o <= '0;
                err_o        <= 1'b0;
                if (valid_i) begin
                    sym_o    <= sym_i;
                    golden_o <= sym_i;
                end
            end else if (valid_i) begin
                golden_o <= sym_i;
                sym_o    <= sym_i ^ (hit_s ? cfg_mask_i : {W{1'b0}});
                err_o    <= hit_s && (cfg_mask_i != '0);
                idx_r    <= idx_nx_s;
                phase_r  <= phase_nx_s;
                if (hit_s) begin
                    bit_err_ct_o <= bit_nx_s;
                end
            end else begin
                err_o <= 1'b0;
            end
        end
    end

    assign sym_ct_o = idx_r;

endmodule

// File: tb/tb_chan_err_inj.sv
// Directed self-checking bench for chan_err_inj: one task per scenario, expected values computed here.
module tb_chan_err_inj;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  sym_i = 2'b00;
    logic [1:0]  mode_i = 2'd0;
    logic [31:0] cfg_start = 32'd0;
    logic [31:0] cfg_len = 32'd0;
    logic [31:0] cfg_period = 32'd0;
    logic [15:0] cfg_thresh = 16'd0;
    logic [1:0]  cfg_mask = 2'b00;
    logic        clear_i = 1'b0;

    logic        valid_o, err_o;
    logic [1:0]  sym_o, golden_o;
    logic [31:0] sym_ct_o, bit_err_ct_o;

    logic        s_valid_o, s_err_o;
    logic [1:0]  s_sym_o, s_golden_o;
    logic [3:0]  s_sym_ct_o, s_bit_err_ct_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    chan_err_inj #(.W(2), .CNT_W(32), .SEED(16'h0001)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
        .cfg_start_i(cfg_start), .cfg_len_i(cfg_len), .cfg_period_i(cfg_period),
        .cfg_thresh_i(cfg_thresh), .cfg_mask_i(cfg_mask), .clear_i(clear_i),
        .valid_o(valid_o), .sym_o(sym_o), .golden_o(golden_o), .err_o(err_o),
        .sym_ct_o(sym_ct_o), .bit_err_ct_o(bit_err_ct_o)
    );

    chan_err_inj #(.W(2), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
        .cfg_start_i(cfg_start[3:0]), .cfg_len_i(cfg_len[3:0]), .cfg_period_i(cfg_period[3:0]),
        .cfg_thresh_i(cfg_thresh), .cfg_mask_i(cfg_mask), .clear_i(clear_i),
        .valid_o(s_valid_o), .sym_o(s_sym_o), .golden_o(s_golden_o), .err_o(s_err_o),
        .sym_ct_o(s_sym_ct_o), .bit_err_ct_o(s_bit_err_ct_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        valid_i = 1'b0;
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_i = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        tests++;
        if ({valid_o, sym_o, golden_o, err_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_out got v=%b s=%b g=%b e=%b exp all 0", valid_o, sym_o, golden_o, err_o);
        end
        tests++;
        if (sym_ct_o !== 32'd0 || bit_err_ct_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_cnt got sym=%0d bit=%0d exp 0 0", sym_ct_o, bit_err_ct_o);
        end
    endtask

    task automatic test_off();
        logic [1:0] s;
        do_clear();
        mode_i = 2'd0;
        cfg_mask = 2'b11;
        for (int i = 0; i < 300; i++) begin
            s = 2'($urandom);
            sym_i = s;
            valid_i = 1'b1;
            cyc();
            tests++;
            if (valid_o !== 1'b1 || sym_o !== s || golden_o !== s || err_o !== 1'b0) begin
                fails++;
                $display("FAIL off_sym i=%0d got v=%b s=%b g=%b e=%b exp 1 %b %b 0", i, valid_o, sym_o, golden_o, err_o, s, s);
            end
        end
        valid_i = 1'b0;
        tests++;
        if (sym_ct_o !== 32'd300 || bit_err_ct_o !== 32'd0) begin
            fails++;
            $display("FAIL off_cnt got sym=%0d bit=%0d exp 300 0", sym_ct_o, bit_err_ct_o);
        end
    endtask

    task automatic test_window();
        logic [1:0] s;
        logic       h;
        do_clear();
        mode_i = 2'd1;
        cfg_start = 32'd247;
        cfg_len = 32'd9;
        cfg_mask = 2'b10;
        for (int i = 0; i < 300; i++) begin
            s = 2'($urandom);
            h = (i >= 247) && (i <= 255);
            sym_i = s;
            valid_i = 1'b1;
            cyc();
            tests++;
            if (err_o !== h || sym_o !== (h ? (s ^ 2'b10) : s) || golden_o !== s) begin
                fails++;
                $display("FAIL window_sym i=%0d got s=%b g=%b e=%b exp s=%b g=%b e=%b", i, sym_o, golden_o, err_o, h ? (s ^ 2'b10) : s, s, h);
            end
        end
        valid_i = 1'b0;
        tests++;
        if (sym_ct_o !== 32'd300 || bit_err_ct_o !== 32'd9) begin
            fails++;
            $display("FAIL window_cnt got sym=%0d bit=%0d exp 300 9", sym_ct_o, bit_err_ct_o);
        end
    endtask

    task automatic test_periodic();
        logic [1:0] s;
        logic [1:0] last;
        logic       h;
        int         k;
        int         hits;
        do_clear();
        mode_i = 2'd2;
        cfg_period = 32'd8;
        cfg_len = 32'd2;
        cfg_mask = 2'b11;
        k = 0;
        hits = 0;
        last = 2'b00;
        for (int c = 0; c < 128; c++) begin
            s = 2'($urandom);
            sym_i = s;
            valid_i = (c % 2 == 0);
            cyc();
            if (c % 2 == 0) begin
                h = (k % 8) < 2;
                if (h) hits++;
                last = h ? (s ^ 2'b11) : s;
                tests++;
                if (valid_o !== 1'b1 || err_o !== h || sym_o !== last) begin
                    fails++;
                    $display("FAIL periodic_sym k=%0d got v=%b s=%b e=%b exp 1 %b %b", k, valid_o, sym_o, err_o, last, h);
                end
                k++;
            end else begin
                tests++;
                if (valid_o !== 1'b0 || err_o !== 1'b0 || sym_o !== last) begin
                    fails++;
                    $display("FAIL periodic_idle c=%0d got v=%b s=%b e=%b exp 0 %b 0", c, valid_o, sym_o, err_o, last);
                end
            end
        end
        valid_i = 1'b0;
        tests++;
        if (hits != 16 || sym_ct_o !== 32'd64 || bit_err_ct_o !== 32'd32) begin
            fails++;
            $display("FAIL periodic_cnt got sym=%0d bit=%0d exp 64 32", sym_ct_o, bit_err_ct_o);
        end
    endtask

    task automatic test_random();
        logic [15:0] lf;
        logic        h;
        int          hits;
        do_clear();
        mode_i = 2'd3;
        cfg_thresh = 16'h8000;
        cfg_mask = 2'b01;
        lf = 16'h0001;
        hits = 0;
        for (int i = 0; i < 4096; i++) begin
            h = lf < 16'h8000;
            if (h) hits++;
            lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
            sym_i = 2'($urandom);
            valid_i = 1'b1;
            cyc();
            tests++;
            if (err_o !== h) begin
                fails++;
                $display("FAIL random_err i=%0d got %b exp %b", i, err_o, h);
            end
        end
        valid_i = 1'b0;
        tests++;
        if (bit_err_ct_o !== 32'(hits) || sym_ct_o !== 32'd4096) begin
            fails++;
            $display("FAIL random_cnt got sym=%0d bit=%0d exp 4096 %0d", sym_ct_o, bit_err_ct_o, hits);
        end
        do_clear();
        cfg_thresh = 16'h0000;
        for (int i = 0; i < 200; i++) begin
            sym_i = 2'($urandom);
            valid_i = 1'b1;
            cyc();
            tests++;
            if (err_o !== 1'b0) begin
                fails++;
                $display("FAIL random_zero i=%0d got %b exp 0", i, err_o);
            end
        end
        valid_i = 1'b0;
        tests++;
        if (bit_err_ct_o !== 32'd0) begin
            fails++;
            $display("FAIL random_zero_cnt got %0d exp 0", bit_err_ct_o);
        end
    endtask

    task automatic test_clear();
        do_clear();
        mode_i = 2'd1;
        cfg_start = 32'd100;
        cfg_len = 32'd5;
        cfg_mask = 2'b11;
        for (int i = 0; i < 100; i++) begin
            sym_i = 2'($urandom);
            valid_i = 1'b1;
            cyc();
        end
        sym_i = 2'b01;
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        tests++;
        if (valid_o !== 1'b1 || sym_o !== 2'b01 || golden_o !== 2'b01 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL clear_sym got v=%b s=%b g=%b e=%b exp 1 01 01 0", valid_o, sym_o, golden_o, err_o);
        end
        tests++;
        if (sym_ct_o !== 32'd0 || bit_err_ct_o !== 32'd0) begin
            fails++;
            $display("FAIL clear_cnt got sym=%0d bit=%0d exp 0 0", sym_ct_o, bit_err_ct_o);
        end
        sym_i = 2'b10;
        cyc();
        valid_i = 1'b0;
        tests++;
        if (sym_o !== 2'b10 || err_o !== 1'b0 || sym_ct_o !== 32'd1 || bit_err_ct_o !== 32'd0) begin
            fails++;
            $display("FAIL clear_next got s=%b e=%b sym=%0d bit=%0d exp 10 0 1 0", sym_o, err_o, sym_ct_o, bit_err_ct_o);
        end
    endtask

    task automatic test_saturate();
        int ec;
        int eb;
        rst = 1'b1;
        valid_i = 1'b0;
        cyc();
        rst = 1'b0;
        mode_i = 2'd2;
        cfg_period = 32'd1;
        cfg_len = 32'd1;
        cfg_mask = 2'b11;
        for (int i = 0; i < 20; i++) begin
            sym_i = 2'b01;
            valid_i = 1'b1;
            cyc();
            ec = (i + 1 > 15) ? 15 : i + 1;
            eb = (2 * (i + 1) > 15) ? 15 : 2 * (i + 1);
            tests++;
            if (s_sym_ct_o !== 4'(ec) || s_bit_err_ct_o !== 4'(eb) || s_err_o !== 1'b1 || s_sym_o !== 2'b10) begin
                fails++;
                $display("FAIL sat_cnt i=%0d got sym=%0d bit=%0d e=%b s=%b exp %0d %0d 1 10", i, s_sym_ct_o, s_bit_err_ct_o, s_err_o, s_sym_o, ec, eb);
            end
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        valid_i = 1'b0;
        tests++;
        if ({s_valid_o, s_sym_o, s_golden_o, s_err_o, s_sym_ct_o, s_bit_err_ct_o} !== 14'b0) begin
            fails++;
            $display("FAIL sat_rst got v=%b s=%b g=%b e=%b sym=%0d bit=%0d exp all 0", s_valid_o, s_sym_o, s_golden_o, s_err_o, s_sym_ct_o, s_bit_err_ct_o);
        end
    endtask

    initial begin
        test_reset();
        test_off();
        test_window();
        test_periodic();
        test_random();
        test_clear();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
